// File: rtl/decode_scoreboard.sv
// decode_scoreboard: per-register pending-write counters for the LC-3b DE stage.
// A counter rises when a writer issues into AGEX and falls when that writer
// either writes back or is squashed, so the hazard check is independent of
// pipeline depth. Produces dep_stall and the issue strobe (ld_agex).
module decode_scoreboard #(
    parameter int NUM_REGS = 8,
    parameter int RID_W    = $clog2(NUM_REGS),
    parameter int CNT_W    = 2,
    parameter int CC_TRACK = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                de_v,
    input  logic [RID_W-1:0]    de_sr1,
    input  logic                de_sr1_needed,
    input  logic [RID_W-1:0]    de_sr2,
    input  logic                de_sr2_needed,
    input  logic [RID_W-1:0]    de_dr,
    input  logic                de_ld_reg,
    input  logic                de_ld_cc,
    input  logic                de_br_op,
    input  logic                pipe_stall,
    input  logic                wb_v,
    input  logic [RID_W-1:0]    wb_drid,
    input  logic                wb_ld_cc,
    input  logic                kill_v,
    input  logic [RID_W-1:0]    kill_drid,
    input  logic                kill_ld_cc,
    input  logic                flush_all,
    output logic                dep_stall,
    output logic                issue,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic                cc_busy,
    output logic                err
);

    // Ids are decoded over the full 2**RID_W space; ids >= NUM_REGS read as idle.
    localparam int ID_SPACE = 1 << RID_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]    r_pend [NUM_REGS];
    logic [CNT_W-1:0]    r_cc_pend;
    logic                r_err;

    logic [ID_SPACE-1:0] w_busy_pad;
    logic [ID_SPACE-1:0] w_full_pad;
    logic                w_cc_busy;
    logic                w_cc_full;
    logic                w_dep_stall;
    logic                w_issue;
    logic [CNT_W-1:0]    w_pend_nxt [NUM_REGS];
    logic [NUM_REGS-1:0] w_uflow;
    logic [CNT_W-1:0]    w_cc_nxt;
    logic                w_cc_uflow;
    logic                w_cc_err;

    // Returns {underflow, next_count}: cur + inc - (dec_a + dec_b), clamped at 0.
    // The MAX check on issue guarantees cur + inc never exceeds CNT_MAX.
    function automatic logic [CNT_W:0] count_step(input logic [CNT_W-1:0] cur,
                                                  input logic inc,
                                                  input logic dec_a,
                                                  input logic dec_b);
        logic [CNT_W+1:0] up;
        logic [CNT_W+1:0] down;
        up   = (CNT_W+2)'(cur) + (CNT_W+2)'(inc);
        down = (CNT_W+2)'(dec_a) + (CNT_W+2)'(dec_b);
        if (down > up) count_step = {1'b1, {CNT_W{1'b0}}};
        else           count_step = {1'b0, CNT_W'(up - down)};
    endfunction

    // Busy/full flags per id, padded to the whole id space.
    always_comb begin
        // NOTE: every signal gets a default before the loop so no path leaves it unassigned (no latch).
        w_busy_pad = '0;
        w_full_pad = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            w_busy_pad[r] = (r_pend[r] != '0);
            w_full_pad[r] = (r_pend[r] == CNT_MAX);
        end
    end

    assign w_cc_busy = (r_cc_pend != '0);
    assign w_cc_full = (r_cc_pend == CNT_MAX);

    // Hazard check against registered counters only: no same-cycle writeback bypass.
    assign w_dep_stall = de_v & ((de_sr1_needed & w_busy_pad[de_sr1])
                               | (de_sr2_needed & w_busy_pad[de_sr2])
                               | (de_br_op      & w_cc_busy)
                               | (de_ld_reg     & w_full_pad[de_dr])
                               | (de_ld_cc      & w_cc_full));

    assign w_issue = de_v & ~w_dep_stall & ~pipe_stall & ~flush_all;

    // Next count per register from issue, writeback and squash events.
    always_comb begin
        w_uflow = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            {w_uflow[r], w_pend_nxt[r]} = count_step(r_pend[r],
                                                     w_issue & de_ld_reg & (de_dr == RID_W'(r)),
                                                     wb_v & (wb_drid == RID_W'(r)),
                                                     kill_v & (kill_drid == RID_W'(r)));
        end
    end

    assign {w_cc_uflow, w_cc_nxt} = count_step(r_cc_pend, w_issue & de_ld_cc, wb_ld_cc, kill_ld_cc);

    // Register pending counters; flush_all overrides every event.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the counter array is real architectural state, so every entry is reset, not just a valid bit.
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) r_pend[r] <= '0;
        end else if (flush_all) begin
            for (int r = 0; r < NUM_REGS; r++) r_pend[r] <= '0;
        end else begin
            // NOTE: non-blocking so every counter updates from the same pre-edge values.
            for (int r = 0; r < NUM_REGS; r++) r_pend[r] <= w_pend_nxt[r];
        end
    end

    generate
        if (CC_TRACK != 0) begin : g_cc
            // CC pending counter, same rules as the register counters.
            always_ff @(posedge clk or posedge reset) begin
                if (reset)          r_cc_pend <= '0;
                else if (flush_all) r_cc_pend <= '0;
                else                r_cc_pend <= w_cc_nxt;
            end
            assign w_cc_err = w_cc_uflow;
        end else begin : g_no_cc
            assign r_cc_pend = '0;
            assign w_cc_err  = 1'b0;
        end
    endgenerate

    // Sticky error: any decrement that would take a counter below zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                       r_err <= 1'b0;
        else if ((|w_uflow) | w_cc_err) r_err <= 1'b1;
    end

    assign dep_stall = w_dep_stall;
    assign issue     = w_issue;
    assign busy_vec  = w_busy_pad[NUM_REGS-1:0];
    assign cc_busy   = w_cc_busy;
    assign err       = r_err;

endmodule
